fetch_npc_stage: RTL and testbench

// - F stage of the 5-stage MIPS pipeline: owns the PC, issues instruction-memory reads, fills F/D register.
// - Consumes b_jump from the D-stage comparator plus D-stage npc_op to pick the next PC.
// - MIPS delay-slot semantics: no flush; a taken transfer redirects after the delay slot is fetched.

---
 rtl/fetch_npc_stage_pkg.sv | 14 +
 rtl/fetch_npc_stage_if.sv | 9 +
 rtl/fetch_npc_stage_npc_calc.sv | 21 ++
 rtl/fetch_npc_stage.sv | 85 ++++++++
 tb/tb_fetch_npc_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_npc_stage_pkg.sv
// mips_defs: transfer kinds, fetch FSM states and reset PC shared by the fetch stage
package mips_defs;
  typedef enum logic [1:0] {
    NPC_PC4 = 2'd0,
    NPC_BEQ = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_t;
  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_t;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/fetch_npc_stage_if.sv
// fetch_npc_stage_if: instruction-memory read bus between the fetch stage and memory
interface fetch_npc_stage_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_ready;
  modport master (output im_req, im_addr, input im_rdata, im_ready);
  modport slave (input im_req, im_addr, output im_rdata, im_ready);
endinterface

// File: rtl/fetch_npc_stage_npc_calc.sv
// npc_calc: transfer target and raw taken decision for the instruction sitting in D
module npc_calc
  import mips_defs::*;
(
  input  logic [31:0] d_pc,
  input  logic [1:0]  npc_op,
  input  logic        b_jump,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index,
  input  logic [31:0] jr_target,
  output logic [31:0] target,
  output logic        taken
);
  // branch offset is relative to the delay slot; all adds wrap mod 2^32
  always_comb begin
    target = npc_op == NPC_JR ? jr_target :
             npc_op == NPC_J  ? {d_pc[31:28], d_index, 2'b00} :
             d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
    taken = npc_op == NPC_J || npc_op == NPC_JR || (npc_op == NPC_BEQ && b_jump);
  end
endmodule

// File: rtl/fetch_npc_stage.sv
// fetch_npc_stage: MIPS F stage owning the PC, the I-memory read and the F/D register
module fetch_npc_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = mips_defs::RESET_PC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall_in,
  input  logic [1:0]                npc_op,
  input  logic                      b_jump,
  input  logic [15:0]               d_imm16,
  input  logic [25:0]               d_index,
  input  logic [31:0]               jr_target,
  fetch_npc_stage_if.master         im,
  output logic [31:0]               d_instr,
  output logic [31:0]               d_pc,
  output logic [31:0]               d_pc8,
  output logic                      d_valid
);
  fetch_state_t state;
  logic [31:0] pc;
  logic [31:0] ibuf;
  logic [31:0] redir_pc;
  logic [31:0] target;
  logic [31:0] npc;
  logic [31:0] word;
  logic        redir_valid;
  logic        taken_raw;
  logic        taken;
  logic        accept;
  logic        hold_word;
  npc_calc u_npc_calc (
    .d_pc      (d_pc),
    .npc_op    (npc_op),
    .b_jump    (b_jump),
    .d_imm16   (d_imm16),
    .d_index   (d_index),
    .jr_target (jr_target),
    .target    (target),
    .taken     (taken_raw)
  );
  assign im.im_req  = state == S_FETCH;
  assign im.im_addr = pc;
  // a pending redirect wins over the D decision: only bubbles sit in D while it is set
  always_comb begin
    taken     = d_valid && taken_raw;
    accept    = ((state == S_FETCH && im.im_ready) || state == S_HOLD) && !stall_in;
    hold_word = state == S_FETCH && im.im_ready && stall_in;
    word      = state == S_HOLD ? ibuf : im.im_rdata;
    npc       = redir_valid ? redir_pc : taken ? target : pc + 32'd4;
  end
  // PC, fetch FSM, word buffer, redirect latch and F/D register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= S_FETCH;
      ibuf        <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      d_instr     <= '0;
      d_pc        <= RESET_PC;
      d_pc8       <= RESET_PC + 32'd8;
      d_valid     <= 1'b0;
    end else if (accept) begin
      d_instr     <= word;
      d_pc        <= pc;
      d_pc8       <= pc + 32'd8;
      d_valid     <= 1'b1;
      pc          <= npc;
      state       <= S_FETCH;
      redir_valid <= 1'b0;
    end else if (hold_word) begin
      ibuf  <= im.im_rdata;
      state <= S_HOLD;
    end else if (!stall_in) begin
      d_instr <= '0;
      d_valid <= 1'b0;
      if (taken) begin
        redir_valid <= 1'b1;
        redir_pc    <= target;
      end
    end
  end
endmodule

// File: tb/tb_fetch_npc_stage.sv
// tb_fetch_npc_stage: directed and random checks of the fetch stage against a program-order model
module tb_fetch_npc_stage;
  import mips_defs::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic [1:0]  npc_op = 2'd0;
  logic        b_jump = 1'b0;
  logic [15:0] d_imm16 = '0;
  logic [25:0] d_index = '0;
  logic [31:0] jr_target = '0;
  logic [31:0] d_instr, d_pc, d_pc8;
  logic        d_valid;
  fetch_npc_stage_if im ();
  fetch_npc_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall_in  (stall_in),
    .npc_op    (npc_op),
    .b_jump    (b_jump),
    .d_imm16   (d_imm16),
    .d_index   (d_index),
    .jr_target (jr_target),
    .im        (im),
    .d_instr   (d_instr),
    .d_pc      (d_pc),
    .d_pc8     (d_pc8),
    .d_valid   (d_valid)
  );
  always #5 clk = ~clk;
  // program-order model: e[n] is the PC of the n-th instruction fetched since reset
  logic [31:0] e  [0:4095];
  logic [31:0] tg [0:4095];
  bit          tk [0:4095];
  int n_acc, md_i, lat, cnt, fixed_lat;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_buf, md_v;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    n_acc = 0;
    e[0]  = 32'h0000_3000;
    m_buf = 1'b0;
    md_v  = 1'b0;
    md_i  = 0;
    cnt   = 0;
    lat   = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
  endtask
  task automatic check_all();
    chk("im_req", 32'(im.im_req), 32'(!m_buf));
    chk("im_addr", im.im_addr, e[n_acc]);
    chk("d_valid", 32'(d_valid), 32'(md_v));
    if (md_v) begin
      chk("d_pc", d_pc, e[md_i]);
      chk("d_pc8", d_pc8, e[md_i] + 32'd8);
      chk("d_instr", d_instr, mem_word(e[md_i]));
    end else begin
      chk("d_instr_bubble", d_instr, 32'd0);
    end
  endtask
  task automatic do_reset(input int fl);
    fixed_lat   = fl;
    reset       = 1'b1;
    stall_in    = 1'b0;
    npc_op      = NPC_PC4;
    b_jump      = 1'b0;
    im.im_ready = 1'b0;
    im.im_rdata = '0;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    check_all();
    chk("rst_d_pc", d_pc, 32'h0000_3000);
    chk("rst_d_pc8", d_pc8, 32'h0000_3008);
  endtask
  // one clock: memory answers after its latency, model advances in program order, then compare
  task automatic step(input bit st, input logic [1:0] op, input bit bj, input logic [15:0] imm,
                      input logic [25:0] idx, input logic [31:0] jt);
    bit rdy, acc;
    stall_in  = st;
    npc_op    = op;
    b_jump    = bj;
    d_imm16   = imm;
    d_index   = idx;
    jr_target = jt;
    rdy = !m_buf && cnt >= lat;
    im.im_ready = rdy;
    im.im_rdata = rdy ? mem_word(im.im_addr) : 32'($urandom());
    @(posedge clk);
    acc = (rdy || m_buf) && !st;
    if (md_v && !st) begin
      tk[md_i] = op == NPC_J || op == NPC_JR || (op == NPC_BEQ && bj);
      tg[md_i] = op == NPC_JR ? jt :
                 op == NPC_J  ? {e[md_i][31:28], idx, 2'b00} :
                 e[md_i] + 32'd4 + 32'($signed(imm)) * 4;
    end
    if (acc) begin
      md_v  = 1'b1;
      md_i  = n_acc;
      n_acc = n_acc + 1;
      e[n_acc] = (n_acc >= 2 && tk[n_acc-2]) ? tg[n_acc-2] : e[n_acc-1] + 32'd4;
      m_buf = 1'b0;
    end else if (!st) begin
      md_v = 1'b0;
    end
    if (rdy && st) m_buf = 1'b1;
    if (rdy) begin
      cnt = 0;
      lat = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
    end else if (!m_buf) begin
      cnt++;
    end
    #1;
    check_all();
  endtask
  bit         r_st;
  logic [1:0] r_op;
  initial begin
    // sequential fetch with zero-latency memory
    do_reset(0);
    step(0, NPC_PC4, 0, 0, 0, 0);
    chk("seq_addr1", im.im_addr, 32'h3004);
    chk("seq_dpc1", d_pc, 32'h3000);
    step(0, NPC_PC4, 0, 0, 0, 0);
    chk("seq_addr2", im.im_addr, 32'h3008);
    chk("seq_dpc2", d_pc, 32'h3004);
    // taken beq at 3004: delay slot 3008 then 3014
    step(0, NPC_BEQ, 1, 16'h0003, 0, 0);
    chk("beq_t_addr", im.im_addr, 32'h3014);
    chk("beq_t_slot", d_pc, 32'h3008);
    step(0, NPC_PC4, 0, 0, 0, 0);
    chk("beq_t_dpc", d_pc, 32'h3014);
    // untaken beq at 3004: falls through to 300C
    do_reset(0);
    step(0, NPC_PC4, 0, 0, 0, 0);
    step(0, NPC_PC4, 0, 0, 0, 0);
    step(0, NPC_BEQ, 0, 16'h0003, 0, 0);
    chk("beq_n_addr", im.im_addr, 32'h300C);
    // j at 3000 to index 0xC40
    do_reset(0);
    step(0, NPC_PC4, 0, 0, 0, 0);
    chk("j_link", d_pc8, 32'h3008);
    step(0, NPC_J, 0, 0, 26'h0000C40, 0);
    chk("j_addr", im.im_addr, 32'h3100);
    chk("j_slot", d_pc, 32'h3004);
    step(0, NPC_PC4, 0, 0, 0, 0);
    chk("j_dpc", d_pc, 32'h3100);
    // two-cycle stall while memory answers
    do_reset(0);
    step(0, NPC_PC4, 0, 0, 0, 0);
    step(1, NPC_PC4, 0, 0, 0, 0);
    chk("hold_req", 32'(im.im_req), 32'd0);
    chk("hold_dpc", d_pc, 32'h3000);
    step(1, NPC_PC4, 0, 0, 0, 0);
    chk("hold_req2", 32'(im.im_req), 32'd0);
    step(0, NPC_PC4, 0, 0, 0, 0);
    chk("hold_rel_dpc", d_pc, 32'h3004);
    chk("hold_rel_addr", im.im_addr, 32'h3008);
    step(0, NPC_PC4, 0, 0, 0, 0);
    chk("hold_next_dpc", d_pc, 32'h3008);
    // jr advancing during a 3-cycle memory wait
    do_reset(3);
    for (int i = 0; i < 4; i++) step(0, NPC_PC4, 0, 0, 0, 0);
    chk("jr_first", d_pc, 32'h3000);
    step(0, NPC_JR, 0, 0, 0, 32'h3200);
    chk("jr_redir_set", 32'(dut.redir_valid), 32'd1);
    chk("jr_bubble", 32'(d_valid), 32'd0);
    step(0, NPC_JR, 1, 16'hFFFF, 26'h3FFFFFF, 32'hDEAD_0000);
    step(0, NPC_PC4, 0, 0, 0, 0);
    step(0, NPC_PC4, 0, 0, 0, 0);
    chk("jr_addr", im.im_addr, 32'h3200);
    chk("jr_redir_clr", 32'(dut.redir_valid), 32'd0);
    chk("jr_slot", d_pc, 32'h3004);
    // asynchronous reset while the fetch is waiting
    do_reset(3);
    for (int i = 0; i < 4; i++) step(0, NPC_PC4, 0, 0, 0, 0);
    step(1, NPC_PC4, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(d_valid), 32'd0);
    chk("arst_addr", im.im_addr, 32'h3000);
    im.im_ready = 1'b1;
    im.im_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    im.im_ready = 1'b0;
    chk("arst_late_valid", 32'(d_valid), 32'd0);
    chk("arst_late_instr", d_instr, 32'd0);
    chk("arst_late_addr", im.im_addr, 32'h3000);
    fixed_lat = 0;
    model_reset();
    step(0, NPC_PC4, 0, 0, 0, 0);
    chk("arst_resume", d_pc, 32'h3000);
    // random latency, stalls and transfers; no taken transfer in a delay slot
    do_reset(-1);
    for (int i = 0; i < 1500; i++) begin
      r_st = $urandom_range(0, 3) == 0;
      r_op = 2'($urandom_range(0, 3));
      if (md_v && md_i > 0 && tk[md_i-1]) r_op = NPC_PC4;
      step(r_st, r_op, 1'($urandom_range(0, 1)), 16'($urandom()), 26'($urandom()), 32'($urandom()));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
